// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - sequences one MAC unit through a programmable-length dot product
module mac_seq_ctrl #(
    parameter int N     = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic [31:0]      bias,
    input  logic             din_vld,
    output logic             din_rdy,
    input  logic [N-1:0]     a_din,
    input  logic [N-1:0]     w_din,
    output logic             addend_vld,
    output logic [31:0]      addend_din,
    output logic             multiplicand_vld,
    output logic [N-1:0]     multiplicand_din,
    output logic [N-1:0]     multiplier_din,
    input  logic [31:0]      mac_dout,
    input  logic             mac_dout_vld,
    output logic [31:0]      acc_dout,
    output logic             acc_dout_vld,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_MUL,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      acc;

    // Every output is a register updated alongside the state transition that enters its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            len_r            <= '0;
            cnt              <= '0;
            acc              <= '0;
            din_rdy          <= 1'b0;
            addend_vld       <= 1'b0;
            addend_din       <= '0;
            multiplicand_vld <= 1'b0;
            multiplicand_din <= '0;
            multiplier_din   <= '0;
            acc_dout         <= '0;
            acc_dout_vld     <= 1'b0;
            busy             <= 1'b0;
            err              <= 1'b0;
        end else begin
            // A MAC result outside WAIT is a protocol violation; its data is dropped.
            if (mac_dout_vld && state != S_WAIT) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_r <= length;
                        acc   <= bias;
                        cnt   <= '0;
                        err   <= mac_dout_vld;
                        busy  <= 1'b1;
                        if (length == '0) begin
                            acc_dout_vld <= 1'b1;
                            acc_dout     <= bias;
                            state        <= S_DONE;
                        end else begin
                            din_rdy <= 1'b1;
                            state   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (din_vld) begin
                        multiplicand_din <= a_din;
                        multiplier_din   <= w_din;
                        din_rdy          <= 1'b0;
                        addend_vld       <= 1'b1;
                        addend_din       <= acc;
                        state            <= S_ADD;
                    end
                end
                S_ADD: begin
                    addend_vld       <= 1'b0;
                    multiplicand_vld <= 1'b1;
                    state            <= S_MUL;
                end
                S_MUL: begin
                    multiplicand_vld <= 1'b0;
                    state            <= S_WAIT;
                end
                S_WAIT: begin
                    if (mac_dout_vld) begin
                        acc <= mac_dout;
                        cnt <= cnt + 1'b1;
                        if (cnt == len_r - 1'b1) begin
                            acc_dout_vld <= 1'b1;
                            acc_dout     <= mac_dout;
                            state        <= S_DONE;
                        end else begin
                            din_rdy <= 1'b1;
                            state   <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    acc_dout_vld <= 1'b0;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - directed self-checking bench for mac_seq_ctrl with a behavioural MAC
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] length = '0;
    logic [31:0] bias = '0;
    logic        din_vld = 1'b0;
    logic        din_rdy;
    logic [31:0] a_din = '0;
    logic [31:0] w_din = '0;
    logic        addend_vld;
    logic [31:0] addend_din;
    logic        multiplicand_vld;
    logic [31:0] multiplicand_din;
    logic [31:0] multiplier_din;
    logic [31:0] mac_dout = '0;
    logic        mac_dout_vld = 1'b0;
    logic [31:0] acc_dout;
    logic        acc_dout_vld;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    mac_seq_ctrl #(.N(32), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length), .bias(bias),
        .din_vld(din_vld), .din_rdy(din_rdy), .a_din(a_din), .w_din(w_din),
        .addend_vld(addend_vld), .addend_din(addend_din),
        .multiplicand_vld(multiplicand_vld), .multiplicand_din(multiplicand_din),
        .multiplier_din(multiplier_din), .mac_dout(mac_dout), .mac_dout_vld(mac_dout_vld),
        .acc_dout(acc_dout), .acc_dout_vld(acc_dout_vld), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: result = addend + multiplicand*multiplier, after lat cycles.
    int          lat = 3;
    int          spur_req = 0;
    int          spur_done = 0;
    int          n_add = 0;
    int          n_mul = 0;
    int          n_res = 0;
    int          ord_err = 0;
    int          stab_err = 0;
    int          cd = 0;
    logic        pending = 1'b0;
    logic        hold_ok = 1'b0;
    logic        prev_add = 1'b0;
    logic [31:0] last_add = '0;
    logic [31:0] hold_w = '0;
    logic [31:0] res = '0;
    logic [31:0] last_res = '0;
    logic [31:0] add_q[$];

    always @(negedge clk) begin
        mac_dout_vld = 1'b0;
        if (!rst_n) hold_ok = 1'b0;
        if (pending) begin
            if (hold_ok && multiplier_din !== hold_w) stab_err++;
            cd--;
            if (cd == 0) begin
                mac_dout_vld = 1'b1;
                mac_dout     = res;
                pending      = 1'b0;
            end
        end
        if (spur_req != spur_done) begin
            mac_dout_vld = 1'b1;
            mac_dout     = 32'hDEAD_BEEF;
            spur_done++;
        end
        if (addend_vld) begin
            add_q.push_back(addend_din);
            n_add++;
            last_add = addend_din;
        end
        if (multiplicand_vld) begin
            n_mul++;
            if (!prev_add) ord_err++;
            res     = last_add + multiplicand_din * multiplier_din;
            hold_w  = multiplier_din;
            hold_ok = 1'b1;
            pending = 1'b1;
            cd      = lat;
        end
        prev_add = addend_vld;
        if (acc_dout_vld) begin
            n_res++;
            last_res = acc_dout;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int base_res = 0;

    task automatic do_start(input logic [31:0] b, input logic [15:0] len);
        @(negedge clk);
        base_res = n_res;
        start  = 1'b1;
        bias   = b;
        length = len;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Returns at the negedge of the MUL cycle.
    task automatic feed_pair(input logic [31:0] a, input logic [31:0] w, input int gap);
        int k;
        for (int i = 0; i < gap; i++) @(negedge clk);
        a_din   = a;
        w_din   = w;
        din_vld = 1'b1;
        k = 0;
        while (!din_rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("din_rdy_seen", {31'd0, din_rdy}, 32'd1);
        @(negedge clk);
        din_vld = 1'b0;
        check("add_vld_t1", {31'd0, addend_vld}, 32'd1);
        check("rdy_low_add", {31'd0, din_rdy}, 32'd0);
        @(negedge clk);
        check("mul_vld_t2", {29'd0, addend_vld, multiplicand_vld, din_rdy}, 32'd2);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp);
        int k;
        k = 0;
        while (n_res == base_res && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, {31'd0, (n_res != base_res)}, 32'd1);
        check(tag, last_res, exp);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_pulses"}, n_res - base_res, 32'd1);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #12;
        check("reset_outputs", {busy, din_rdy, addend_vld, multiplicand_vld, acc_dout_vld, err,
                                26'd0} | acc_dout | addend_din | multiplier_din, 32'd0);
        rst_n = 1'b1;

        // Basic 3-pair dot product with addend ordering.
        lat = 3;
        add_q.delete();
        do_start(32'd10, 16'd3);
        feed_pair(32'd1, 32'd2, 0);
        feed_pair(32'd3, 32'd4, 0);
        feed_pair(32'd5, 32'd6, 0);
        wait_done("basic_sum", 32'd54);
        check("addend_count", add_q.size(), 32'd3);
        if (add_q.size() == 3) begin
            check("addend0", add_q[0], 32'd10);
            check("addend1", add_q[1], 32'd12);
            check("addend2", add_q[2], 32'd24);
        end
        check("order_errors", ord_err, 32'd0);

        // Zero length: bias comes straight back, no MAC traffic.
        add_q.delete();
        do_start(32'd7, 16'd0);
        check("len0_vld", {31'd0, acc_dout_vld}, 32'd1);
        check("len0_dout", acc_dout, 32'd7);
        wait_done("len0_sum", 32'd7);
        check("len0_no_addend", add_q.size(), 32'd0);

        // Gaps between pairs, short and long MAC latency.
        lat = 1;
        do_start(32'd100, 16'd2);
        feed_pair(32'd7, 32'd8, 5);
        feed_pair(32'd9, 32'd10, 5);
        wait_done("lat1_sum", 32'd246);
        lat = 9;
        do_start(32'd0, 16'd2);
        feed_pair(32'd2, 32'd3, 5);
        feed_pair(32'd4, 32'd5, 5);
        check("rdy_low_wait", {31'd0, din_rdy}, 32'd0);
        wait_done("lat9_sum", 32'd26);
        check("mult_stable", stab_err, 32'd0);

        // Start during WAIT is ignored.
        lat = 6;
        do_start(32'd1, 16'd1);
        feed_pair(32'd2, 32'd5, 0);
        @(negedge clk);
        start  = 1'b1;
        bias   = 32'd99;
        length = 16'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_start_sum", 32'd11);

        // Spurious MAC result in LOAD sets err, data ignored; next start clears it.
        lat = 2;
        do_start(32'd4, 16'd1);
        spur_req++;
        @(negedge clk);
        @(negedge clk);
        check("spur_err", {31'd0, err}, 32'd1);
        feed_pair(32'd3, 32'd3, 0);
        wait_done("spur_sum", 32'd13);
        do_start(32'd0, 16'd0);
        check("err_cleared", {31'd0, err}, 32'd0);
        wait_done("clr_sum", 32'd0);

        // Accumulator wraps modulo 2^32.
        do_start(32'hFFFF_FFFF, 16'd1);
        feed_pair(32'd1, 32'd1, 0);
        wait_done("wrap_sum", 32'd0);

        // Async reset in WAIT of pair 2 of 4, then late result and a fresh run.
        lat = 5;
        do_start(32'd0, 16'd4);
        feed_pair(32'd1, 32'd1, 0);
        feed_pair(32'd1, 32'd1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", {busy, din_rdy, addend_vld, multiplicand_vld, acc_dout_vld, err,
                                 26'd0} | acc_dout | addend_din | multiplicand_din | multiplier_din,
              32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("late_result_err", {31'd0, err}, 32'd1);
        check("late_no_result", {31'd0, busy}, 32'd0);
        do_start(32'd0, 16'd1);
        check("fresh_err_clr", {31'd0, err}, 32'd0);
        feed_pair(32'd2, 32'd3, 0);
        wait_done("fresh_sum", 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
